bcd_stopwatch_ctrl: RTL and testbench

//  Parametrised successor of the BCD stopwatch: a HH:MM:SS counter with start/stop/clear

---
 rtl/bcd_stopwatch_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// HH:MM:SS BCD stopwatch controller with prescaler, up/down count, preset load and done pulse.
// Optional lap capture register enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch_ctrl #(
   parameter int unsigned TICK_DIV   = 1,
   parameter int unsigned HOUR_LIMIT = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        dir,
   input  logic        load,
   input  logic [21:0] preset,
`ifdef STOPWATCH_LAP_EN
   input  logic        lap,
   output logic [21:0] lap_bcd,
`endif
   output logic [3:0]  h1,
   output logic [3:0]  h2,
   output logic [2:0]  m1,
   output logic [3:0]  m2,
   output logic [2:0]  s1,
   output logic [3:0]  s2,
   output logic        running,
   output logic        sec_tick,
   output logic        done
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0] HOUR_LAST = 8'(HOUR_LIMIT - 1);
   localparam logic [7:0] HOUR_LIM8 = 8'(HOUR_LIMIT);
   localparam logic [3:0] HMAX1 = 4'((HOUR_LIMIT - 1) / 10);
   localparam logic [3:0] HMAX2 = 4'((HOUR_LIMIT - 1) % 10);

   typedef struct packed {
      logic [3:0] h1;
      logic [3:0] h2;
      logic [2:0] m1;
      logic [3:0] m2;
      logic [2:0] s1;
      logic [3:0] s2;
   } bcd_t;

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            dir_q, dir_d;
   bcd_t            count_q, count_d;
   logic            tick_q, tick_d;
   logic            done_q, done_d;
`ifdef STOPWATCH_LAP_EN
   bcd_t            lap_q, lap_d;
`endif

   bcd_t            up, dn, pre;
   logic            wrap_up, dn_zero, preset_ok, step, start_ok;
   logic [7:0]      hours, pre_hours;

   assign hours     = ({4'd0, count_q.h1} * 8'd10) + {4'd0, count_q.h2};
   assign pre       = bcd_t'(preset);
   assign pre_hours = ({4'd0, pre.h1} * 8'd10) + {4'd0, pre.h2};

   // Preset must be well-formed BCD within the configured hour range.
   assign preset_ok = (pre.h1 <= 4'd9) && (pre.h2 <= 4'd9) && (pre.m1 <= 3'd5) &&
                      (pre.m2 <= 4'd9) && (pre.s1 <= 3'd5) && (pre.s2 <= 4'd9) &&
                      (pre_hours < HOUR_LIM8);

   // Increment with carry chain; hours roll over at HOUR_LIMIT.
   always_comb begin
      up      = count_q;
      wrap_up = 1'b0;
      if (count_q.s2 != 4'd9) begin
         up.s2 = count_q.s2 + 4'd1;
      end else begin
         up.s2 = 4'd0;
         if (count_q.s1 != 3'd5) begin
            up.s1 = count_q.s1 + 3'd1;
         end else begin
            up.s1 = 3'd0;
            if (count_q.m2 != 4'd9) begin
               up.m2 = count_q.m2 + 4'd1;
            end else begin
               up.m2 = 4'd0;
               if (count_q.m1 != 3'd5) begin
                  up.m1 = count_q.m1 + 3'd1;
               end else begin
                  up.m1 = 3'd0;
                  if (hours == HOUR_LAST) begin
                     up.h1   = 4'd0;
                     up.h2   = 4'd0;
                     wrap_up = 1'b1;
                  end else if (count_q.h2 != 4'd9) begin
                     up.h2 = count_q.h2 + 4'd1;
                  end else begin
                     up.h2 = 4'd0;
                     up.h1 = count_q.h1 + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Decrement with borrow chain; underflow from zero hours wraps to HOUR_LIMIT-1.
   always_comb begin
      dn = count_q;
      if (count_q.s2 != 4'd0) begin
         dn.s2 = count_q.s2 - 4'd1;
      end else begin
         dn.s2 = 4'd9;
         if (count_q.s1 != 3'd0) begin
            dn.s1 = count_q.s1 - 3'd1;
         end else begin
            dn.s1 = 3'd5;
            if (count_q.m2 != 4'd0) begin
               dn.m2 = count_q.m2 - 4'd1;
            end else begin
               dn.m2 = 4'd9;
               if (count_q.m1 != 3'd0) begin
                  dn.m1 = count_q.m1 - 3'd1;
               end else begin
                  dn.m1 = 3'd5;
                  if (hours == 8'd0) begin
                     dn.h1 = HMAX1;
                     dn.h2 = HMAX2;
                  end else if (count_q.h2 != 4'd0) begin
                     dn.h2 = count_q.h2 - 4'd1;
                  end else begin
                     dn.h2 = 4'd9;
                     dn.h1 = count_q.h1 - 4'd1;
                  end
               end
            end
         end
      end
      dn_zero = (dn == '0);
   end

   assign step     = (state_q == StRun) && (presc_q == PRESC_MAX);
   // A countdown start from 00:00:00 has nothing to count, so it is treated as absent.
   assign start_ok = start && !((state_q == StIdle) && dir && (count_q == '0));

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      dir_d   = dir_q;
      count_d = count_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_d   = lap_q;
`endif
      if (clear) begin
         state_d = StIdle;
         presc_d = '0;
         count_d = '0;
`ifdef STOPWATCH_LAP_EN
         lap_d   = '0;
`endif
      end else begin
         if (state_q == StRun) begin
            presc_d = step ? '0 : presc_q + 1'b1;
            if (step) begin
               tick_d  = 1'b1;
               count_d = dir_q ? dn : up;
               done_d  = dir_q ? dn_zero : wrap_up;
            end
         end
`ifdef STOPWATCH_LAP_EN
         if (lap && (state_q != StIdle)) begin
            lap_d = count_q;
         end
`endif
         if (step && dir_q && dn_zero) begin
            state_d = StIdle;
         end else if (stop) begin
            if (state_q == StRun) begin
               state_d = StPause;
            end
         end else if (start_ok) begin
            case (state_q)
               StIdle: begin
                  state_d = StRun;
                  dir_d   = dir;
                  presc_d = '0;
               end
               StPause: state_d = StRun;
               default: state_d = state_q;
            endcase
         end else if (load && (state_q == StIdle) && preset_ok) begin
            count_d = pre;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         presc_q <= '0;
         dir_q   <= 1'b0;
         count_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dir_q   <= dir_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
`ifdef STOPWATCH_LAP_EN
         lap_q   <= lap_d;
`endif
      end
   end

   assign h1       = count_q.h1;
   assign h2       = count_q.h2;
   assign m1       = count_q.m1;
   assign m2       = count_q.m2;
   assign s1       = count_q.s1;
   assign s2       = count_q.s2;
   assign running  = (state_q == StRun);
   assign sec_tick = tick_q;
   assign done     = done_q;
`ifdef STOPWATCH_LAP_EN
   assign lap_bcd  = lap_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: two instances (TICK_DIV 1/HOUR_LIMIT 24, TICK_DIV 4/HOUR_LIMIT 12)
// compared each cycle against a seconds-count reference model; lap checks under STOPWATCH_LAP_EN.
module tb_bcd_stopwatch_ctrl;

   localparam int IDLE = 0;
   localparam int RUN  = 1;
   localparam int PAUSE = 2;

   logic clk, reset, start, stop, clear, dir, load;
   logic [21:0] preset;
`ifdef STOPWATCH_LAP_EN
   logic lap;
   logic [21:0] a_lap, b_lap;
   logic [21:0] lap_o [2];
`endif
   logic [3:0] a_h1, a_h2, a_m2, a_s2, b_h1, b_h2, b_m2, b_s2;
   logic [2:0] a_m1, a_s1, b_m1, b_s1;
   logic a_run, a_tick, a_done, b_run, b_tick, b_done;

   logic [21:0] disp [2];
   logic run_o [2];
   logic tick_o [2];
   logic done_o [2];

   int td [2] = '{1, 4};
   int hl [2] = '{24, 12};
   int m_state [2];
   int m_secs [2];
   int m_presc [2];
   int m_dirq [2];
   int m_tick [2];
   int m_done [2];
   logic [21:0] m_lap [2];

   int n_err = 0;
   int n_chk = 0;

   bcd_stopwatch_ctrl #(.TICK_DIV(1), .HOUR_LIMIT(24)) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .dir(dir),
      .load(load), .preset(preset),
`ifdef STOPWATCH_LAP_EN
      .lap(lap), .lap_bcd(a_lap),
`endif
      .h1(a_h1), .h2(a_h2), .m1(a_m1), .m2(a_m2), .s1(a_s1), .s2(a_s2),
      .running(a_run), .sec_tick(a_tick), .done(a_done)
   );

   bcd_stopwatch_ctrl #(.TICK_DIV(4), .HOUR_LIMIT(12)) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .dir(dir),
      .load(load), .preset(preset),
`ifdef STOPWATCH_LAP_EN
      .lap(lap), .lap_bcd(b_lap),
`endif
      .h1(b_h1), .h2(b_h2), .m1(b_m1), .m2(b_m2), .s1(b_s1), .s2(b_s2),
      .running(b_run), .sec_tick(b_tick), .done(b_done)
   );

   assign disp[0]   = {a_h1, a_h2, a_m1, a_m2, a_s1, a_s2};
   assign disp[1]   = {b_h1, b_h2, b_m1, b_m2, b_s1, b_s2};
   assign run_o[0]  = a_run;
   assign run_o[1]  = b_run;
   assign tick_o[0] = a_tick;
   assign tick_o[1] = b_tick;
   assign done_o[0] = a_done;
   assign done_o[1] = b_done;
`ifdef STOPWATCH_LAP_EN
   assign lap_o[0]  = a_lap;
   assign lap_o[1]  = b_lap;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [21:0] mk(int a, int b, int c, int d, int e, int f);
      return {4'(a), 4'(b), 3'(c), 4'(d), 3'(e), 4'(f)};
   endfunction

   function automatic logic [21:0] secs_to_bcd(int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return mk(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
   endfunction

   function automatic int bcd_to_secs(logic [21:0] b);
      int h, m, s;
      h = int'(b[21:18]) * 10 + int'(b[17:14]);
      m = int'(b[13:11]) * 10 + int'(b[10:7]);
      s = int'(b[6:4]) * 10 + int'(b[3:0]);
      return h * 3600 + m * 60 + s;
   endfunction

   function automatic bit preset_valid(logic [21:0] b, int hlim);
      int h;
      h = int'(b[21:18]) * 10 + int'(b[17:14]);
      return (b[21:18] <= 9) && (b[17:14] <= 9) && (b[13:11] <= 5) && (b[10:7] <= 9) &&
             (b[6:4] <= 5) && (b[3:0] <= 9) && (h < hlim);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = IDLE;
         m_secs[i]  = 0;
         m_presc[i] = 0;
         m_dirq[i]  = 0;
         m_tick[i]  = 0;
         m_done[i]  = 0;
         m_lap[i]   = '0;
      end
   endtask

   // One clock edge of the reference: count held as plain seconds since 00:00:00.
   task automatic model_clk(int i);
      int  n;
      bit  stp, hit_zero;
      n = hl[i] * 3600;
      m_tick[i] = 0;
      m_done[i] = 0;
      if (!reset) begin
         model_reset();
         return;
      end
      if (clear) begin
         m_state[i] = IDLE;
         m_secs[i]  = 0;
         m_presc[i] = 0;
         m_lap[i]   = '0;
         return;
      end
      stp = (m_state[i] == RUN) && (m_presc[i] == td[i] - 1);
      hit_zero = 0;
      if (m_state[i] == RUN) m_presc[i] = stp ? 0 : m_presc[i] + 1;
`ifdef STOPWATCH_LAP_EN
      if (lap && m_state[i] != IDLE) m_lap[i] = secs_to_bcd(m_secs[i]);
`endif
      if (stp) begin
         m_tick[i] = 1;
         if (m_dirq[i] == 0) begin
            m_secs[i] = (m_secs[i] + 1) % n;
            m_done[i] = (m_secs[i] == 0);
         end else begin
            m_secs[i] = (m_secs[i] == 0) ? n - 1 : m_secs[i] - 1;
            if (m_secs[i] == 0) begin
               m_done[i] = 1;
               hit_zero  = 1;
            end
         end
      end
      if (hit_zero) begin
         m_state[i] = IDLE;
      end else if (stop) begin
         if (m_state[i] == RUN) m_state[i] = PAUSE;
      end else if (start && !(m_state[i] == IDLE && dir && m_secs[i] == 0)) begin
         if (m_state[i] == IDLE) begin
            m_state[i] = RUN;
            m_dirq[i]  = int'(dir);
            m_presc[i] = 0;
         end else if (m_state[i] == PAUSE) begin
            m_state[i] = RUN;
         end
      end else if (load && m_state[i] == IDLE && preset_valid(preset, hl[i])) begin
         m_secs[i] = bcd_to_secs(preset);
      end
   endtask

   task automatic compare(int i);
      check_eq($sformatf("d%0d.disp", i), 32'(disp[i]), 32'(secs_to_bcd(m_secs[i])));
      check_eq($sformatf("d%0d.running", i), 32'(run_o[i]), 32'(m_state[i] == RUN));
      check_eq($sformatf("d%0d.sec_tick", i), 32'(tick_o[i]), 32'(m_tick[i]));
      check_eq($sformatf("d%0d.done", i), 32'(done_o[i]), 32'(m_done[i]));
`ifdef STOPWATCH_LAP_EN
      check_eq($sformatf("d%0d.lap_bcd", i), 32'(lap_o[i]), 32'(m_lap[i]));
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_clk(i);
      for (int i = 0; i < 2; i++) compare(i);
   endtask

   task automatic quiet();
      start = 0; stop = 0; clear = 0; dir = 0; load = 0; preset = '0;
`ifdef STOPWATCH_LAP_EN
      lap = 0;
`endif
   endtask

   task automatic do_clear();
      quiet();
      clear = 1;
      cycle();
      clear = 0;
   endtask

   initial begin
      int r;
      reset = 0;
      quiet();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) compare(i);
      reset = 1;
      cycle();

      // Free-running count past a minute boundary on the 1-cycle-per-second instance.
      start = 1;
      cycle();
      start = 0;
      check_eq("a.start_running", 32'(a_run), 32'd1);
      repeat (59) cycle();
      check_eq("a.at_59", 32'(disp[0]), 32'(mk(0, 0, 0, 0, 5, 9)));
      cycle();
      check_eq("a.min_roll", 32'(disp[0]), 32'(mk(0, 0, 0, 1, 0, 0)));
      do_clear();

      // Pause/resume keeps the prescaler phase on the divide-by-4 instance.
      start = 1;
      cycle();
      start = 0;
      repeat (5) cycle();
      stop = 1;
      cycle();
      stop = 0;
      repeat (10) cycle();
      check_eq("b.paused", 32'(disp[1]), 32'(mk(0, 0, 0, 0, 0, 1)));
      start = 1;
      cycle();
      start = 0;
      cycle();
      check_eq("b.resume1", 32'(disp[1]), 32'(mk(0, 0, 0, 0, 0, 1)));
      cycle();
      check_eq("b.resume2", 32'(disp[1]), 32'(mk(0, 0, 0, 0, 0, 2)));
      do_clear();

      // Day wrap: 23:59:58 is valid for HOUR_LIMIT 24 but rejected for HOUR_LIMIT 12.
      load = 1;
      preset = mk(2, 3, 5, 9, 5, 8);
      cycle();
      quiet();
      check_eq("b.preset_reject", 32'(disp[1]), 32'd0);
      start = 1;
      cycle();
      start = 0;
      cycle();
      check_eq("a.2359_59", 32'(disp[0]), 32'(mk(2, 3, 5, 9, 5, 9)));
      cycle();
      check_eq("a.wrap_zero", 32'(disp[0]), 32'd0);
      check_eq("a.wrap_done", 32'(a_done), 32'd1);
      cycle();
      check_eq("a.done_1cyc", 32'(a_done), 32'd0);
      check_eq("a.wrap_running", 32'(a_run), 32'd1);
      do_clear();

      // Countdown to zero returns to idle; a further down-start from zero is ignored.
      load = 1;
      preset = mk(0, 0, 0, 0, 0, 3);
      cycle();
      quiet();
      start = 1;
      dir = 1;
      cycle();
      quiet();
      cycle();
      check_eq("a.down2", 32'(disp[0]), 32'(mk(0, 0, 0, 0, 0, 2)));
      repeat (2) cycle();
      check_eq("a.down_zero_done", 32'(a_done), 32'd1);
      check_eq("a.down_idle", 32'(a_run), 32'd0);
      start = 1;
      dir = 1;
      cycle();
      quiet();
      check_eq("a.zero_start_ign", 32'(a_run), 32'd0);
      do_clear();

      // Invalid preset and load during RUN are both ignored.
      load = 1;
      preset = mk(0, 0, 0, 0, 0, 10);
      cycle();
      check_eq("a.bad_preset", 32'(disp[0]), 32'd0);
      preset = mk(0, 0, 1, 0, 0, 0);
      cycle();
      quiet();
      start = 1;
      cycle();
      quiet();
      load = 1;
      preset = mk(0, 0, 2, 0, 0, 0);
      cycle();
      quiet();
      check_eq("a.load_in_run", 32'(disp[0]), 32'(mk(0, 0, 1, 0, 0, 1)));
      do_clear();

`ifdef STOPWATCH_LAP_EN
      // Lap on a step edge captures the pre-step count.
      start = 1;
      cycle();
      start = 0;
      repeat (5) cycle();
      lap = 1;
      cycle();
      lap = 0;
      check_eq("a.lap_val", 32'(a_lap), 32'(mk(0, 0, 0, 0, 0, 5)));
      check_eq("a.lap_disp", 32'(disp[0]), 32'(mk(0, 0, 0, 0, 0, 6)));
      do_clear();
      check_eq("a.lap_clear", 32'(a_lap), 32'd0);
`endif

      // Asynchronous reset in the middle of a run.
      start = 1;
      cycle();
      start = 0;
      repeat (6) cycle();
      #2;
      reset = 0;
      model_reset();
      #1;
      check_eq("a.async_rst_run", 32'(a_run), 32'd0);
      for (int i = 0; i < 2; i++) compare(i);
      repeat (2) cycle();
      reset = 1;
      cycle();

      // Randomized control traffic.
      for (int k = 0; k < 4000; k++) begin
         clear = ($urandom_range(0, 63) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         start = ($urandom_range(0, 5) == 0);
         load  = ($urandom_range(0, 7) == 0);
         dir   = 1'($urandom_range(0, 1));
`ifdef STOPWATCH_LAP_EN
         lap   = ($urandom_range(0, 9) == 0);
`endif
         r = $urandom_range(0, 4);
         case (r)
            0: preset = 22'($urandom);
            1: preset = secs_to_bcd($urandom_range(0, 12 * 3600 - 1));
            2: preset = secs_to_bcd($urandom_range(0, 6));
            3: preset = secs_to_bcd(24 * 3600 - $urandom_range(1, 5));
            default: preset = secs_to_bcd(12 * 3600 - $urandom_range(1, 5));
         endcase
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
